alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter INT_SIZE, 16, operand/result width.
REQ-002 Parameter FIFO_DEPTH, 4, instruction FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_instr  input  20  {opcode[19:16], operand[15:0]}.
REQ-007 in_ready  output  1  FIFO not full; transfer when in_valid && in_ready at clk edge.
REQ-008 alu_load  output  1  registered; drives ALU load.
REQ-009 alu_in_val  output  16  registered; drives ALU in_val.
REQ-010 alu_opcode  output  4  registered; drives ALU opcode.
REQ-011 alu_result  input  16  ALU out_val.
REQ-012 res_valid  output  1  result held; cleared on res_valid && res_ready edge.
REQ-013 res_data  output  16  captured result, stable while res_valid.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-016 in_ready SHALL be !full from registered state; push while full is ignored even if a pop occurs that cycle.
REQ-017 FSM states SHALL be IDLE, ISSUE, EMIT_WAIT, EMIT_CAP.
REQ-018 IDLE->ISSUE when FIFO non-empty; ISSUE->IDLE when FIFO empty and no pop.
REQ-019 In ISSUE, head SHALL pop once per cycle unless head is SEQ_EMIT and res_valid=1 (stall, no pop).
REQ-020 Popped SEQ_LOAD: next cycle alu_load=1, alu_in_val=operand, alu_opcode=SEQ_NOP.
REQ-021 Popped ALU_ADD/ALU_MUL: next cycle alu_load=0, alu_in_val=operand, alu_opcode=op.
REQ-022 Popped SEQ_NOP, or any opcode not listed in REQ-020/021/023: alu_load=0, alu_opcode=SEQ_NOP, alu_in_val=0.
REQ-023 Popped SEQ_EMIT: drive NOP; ISSUE->EMIT_WAIT->EMIT_CAP, one cycle each, no pops during either.
REQ-024 In EMIT_CAP, edge SHALL load res_data<=alu_result and set res_valid; then ->ISSUE if FIFO non-empty, else IDLE.
REQ-025 Whenever no pop occurs, next-cycle ALU drive SHALL be NOP (load=0, in_val=0).
REQ-026 Latency: instruction pushed at edge t drives ALU in cycle after edge t+1; result of EMIT popped at edge p is valid from edge p+2.
REQ-027 Arithmetic is performed by the ALU only; products wrap modulo 2^16.
REQ-028 res_valid=1 with res_ready=0 SHALL NOT block non-EMIT instructions.

Reset
REQ-029 rst=1 SHALL immediately, without clk, empty the FIFO, set state IDLE, and set in_ready=1 (once rst deasserts), alu_load=0, alu_in_val=0, alu_opcode=SEQ_NOP, res_valid=0, res_data=0, busy=0.
REQ-030 Reset mid-operation SHALL discard queued instructions and any pending capture; the ALU's own reset is driven separately.

Structure
REQ-031 SEQ_LOAD=4'hD, SEQ_EMIT=4'hE, SEQ_NOP=4'hF SHALL be added to the shared opcodes include next to ALU_ADD/ALU_MUL; 4'hC reserved.
REQ-032 Instruction FIFO SHALL be sub-module seq_fifo (parameterised width/depth, registered full/empty).

Verification
REQ-033 Push LOAD 5, ADD 3, EMIT; res_ready=1 -> res_data=8, res_valid one cycle.
REQ-034 LOAD 300, MUL 300, EMIT -> res_data=24464 (90000 mod 65536).
REQ-035 res_ready=0; push LOAD 1, EMIT, EMIT, then 4 more -> second EMIT stalls, in_ready=0 with 4 queued; res_ready=1 -> second result=1, FIFO drains.
REQ-036 FIFO empty for 10 cycles -> alu_load=0, alu_opcode=4'hF, busy=0 throughout.
REQ-037 Assert rst between clk edges during EMIT_WAIT -> outputs at reset values before next edge, no res_valid; then LOAD 7, EMIT -> 7.
REQ-038 LOAD 2, opcode 4'hC operand 9, EMIT -> res_data=2.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : alu_sequencer_pkg                                           |
// | Purpose  : Shared opcode map and FSM state type for the ALU sequencer. |
// |            ALU_ADD/ALU_MUL are executed by the external ALU; the SEQ_* |
// |            codes are consumed by the sequencer itself.                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package alu_sequencer_pkg;

  localparam int OPCODE_W = 4;

  // ALU-executed opcodes
  localparam logic [OPCODE_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] ALU_MUL  = 4'h1;
  // Sequencer-level opcodes (4'hC is reserved and behaves as a NOP)
  localparam logic [OPCODE_W-1:0] SEQ_RSVD = 4'hC;
  localparam logic [OPCODE_W-1:0] SEQ_LOAD = 4'hD;
  localparam logic [OPCODE_W-1:0] SEQ_EMIT = 4'hE;
  localparam logic [OPCODE_W-1:0] SEQ_NOP  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_EMIT_WAIT = 2'd2,
    ST_EMIT_CAP  = 2'd3
  } seq_state_t;

  // True for opcodes that are forwarded to the ALU unchanged.
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seq_fifo                                                    |
// | Purpose  : Synchronous instruction FIFO with registered full/empty     |
// |            flags and a fall-through head (dout shows the oldest entry).|
// | Ports    : clk, rst         clock, async active-high reset             |
// |            push, din        write request / data (ignored when full)   |
// |            pop, dout        read request / head data (ignored if empty)|
// |            full, empty      registered status flags                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module seq_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push against a full FIFO is dropped even if a pop frees a slot in
  // the same cycle; this keeps in_ready a pure function of registered state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : alu_sequencer                                               |
// | Purpose  : Queues instructions and drives an external accumulator ALU  |
// |            one instruction per cycle; EMIT captures the ALU result     |
// |            into a valid/ready result register.                        |
// | Ports    : clk, rst                 clock, async active-high reset     |
// |            in_valid/in_ready/in_instr  instruction input {op,operand}  |
// |            alu_load/alu_in_val/alu_opcode  registered ALU drive        |
// |            alu_result               ALU output value                   |
// |            res_valid/res_ready/res_data  captured result handshake     |
// |            busy                     FIFO non-empty or FSM active       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int INT_SIZE   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [INT_SIZE+OPCODE_W-1:0] in_instr,
  output logic                         in_ready,
  output logic                         alu_load,
  output logic [INT_SIZE-1:0]          alu_in_val,
  output logic [OPCODE_W-1:0]          alu_opcode,
  input  logic [INT_SIZE-1:0]          alu_result,
  output logic                         res_valid,
  output logic [INT_SIZE-1:0]          res_data,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam int INSTR_W = INT_SIZE + OPCODE_W;

  seq_state_t           state;
  logic [INSTR_W-1:0]   head;
  logic [OPCODE_W-1:0]  head_op;
  logic [INT_SIZE-1:0]  head_operand;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_stall;
  logic                 pop;

  seq_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_instr),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op      = head[INSTR_W-1:INT_SIZE];
  assign head_operand = head[INT_SIZE-1:0];
  assign in_ready     = !fifo_full;
  assign busy         = !fifo_empty || (state != ST_IDLE);

  // An EMIT cannot overwrite a result the consumer has not taken yet.
  assign head_stall = (head_op == SEQ_EMIT) && res_valid;

  // IDLE issues directly so a freshly pushed instruction reaches the ALU
  // one cycle after it lands in the FIFO.
  assign pop = ((state == ST_IDLE) || (state == ST_ISSUE)) &&
               !fifo_empty && !head_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      alu_load   <= 1'b0;
      alu_in_val <= '0;
      alu_opcode <= SEQ_NOP;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      // ALU sees a NOP on every cycle that does not follow a pop.
      alu_load   <= 1'b0;
      alu_in_val <= '0;
      alu_opcode <= SEQ_NOP;

      if (res_valid && res_ready) res_valid <= 1'b0;

      case (state)
        ST_IDLE, ST_ISSUE: begin
          if (pop) begin
            state <= ST_ISSUE;
            if (head_op == SEQ_LOAD) begin
              alu_load   <= 1'b1;
              alu_in_val <= head_operand;
            end else if (is_alu_op(head_op)) begin
              alu_in_val <= head_operand;
              alu_opcode <= head_op;
            end else if (head_op == SEQ_EMIT) begin
              // Two NOP cycles let the preceding op settle in the ALU.
              state <= ST_EMIT_WAIT;
            end
          end else if (!fifo_empty) begin
            state <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_EMIT_WAIT: begin
          state <= ST_EMIT_CAP;
        end

        ST_EMIT_CAP: begin
          res_data  <= alu_result;
          res_valid <= 1'b1;
          state     <= fifo_empty ? ST_IDLE : ST_ISSUE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_alu_sequencer                                            |
// | Purpose  : Directed testbench with a result scoreboard and a simple    |
// |            accumulator ALU model attached to the sequencer.            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_instr;
  logic        in_ready;
  logic        alu_load;
  logic [15:0] alu_in_val;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  alu_sequencer #(
    .INT_SIZE   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .alu_load   (alu_load),
    .alu_in_val (alu_in_val),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  // Accumulator ALU: registered, result visible the cycle after the op.
  logic [15:0] acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (alu_load) acc <= alu_in_val;
    else if (alu_opcode == ALU_ADD) acc <= acc + alu_in_val;
    else if (alu_opcode == ALU_MUL) acc <= 16'(acc * alu_in_val);
  end
  assign alu_result = acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        check("result", 32'(res_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [3:0] op, input logic [15:0] operand,
                      input bit expect_res, input logic [15:0] exp);
    int n;
    if (expect_res) sb_q.push_back(exp);
    in_valid = 1'b1;
    in_instr = {op, operand};
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("push_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy || res_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", (n >= 300) ? 1 : 0, 0);
  endtask

  task automatic check_drive(input string name, input logic ld,
                             input logic [15:0] val, input logic [3:0] op);
    check({name, "_load"},   32'(alu_load),   32'(ld));
    check({name, "_in_val"}, 32'(alu_in_val), 32'(val));
    check({name, "_opcode"}, 32'(alu_opcode), 32'(op));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_busy",      32'(busy),      0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data",  32'(res_data),  0);
    check_drive("rst", 1'b0, 16'd0, 4'hF);

    // LOAD 5, ADD 3, EMIT -> 8
    push(SEQ_LOAD, 16'd5, 0, 0);
    push(ALU_ADD,  16'd3, 0, 0);
    push(SEQ_EMIT, 16'd0, 1, 16'd8);
    drain();

    // LOAD 300, MUL 300, EMIT -> 90000 mod 65536
    push(SEQ_LOAD, 16'd300, 0, 0);
    push(ALU_MUL,  16'd300, 0, 0);
    @(posedge clk); #1;
    check_drive("mul", 1'b0, 16'd300, ALU_MUL);
    push(SEQ_EMIT, 16'd0, 1, 16'd24464);
    drain();

    // Back-pressure: second EMIT stalls, FIFO fills
    res_ready = 1'b0;
    push(SEQ_LOAD, 16'd1, 0, 0);
    push(SEQ_EMIT, 16'd0, 1, 16'd1);
    push(SEQ_EMIT, 16'd0, 1, 16'd1);
    push(ALU_ADD,  16'd1, 0, 0);
    push(ALU_ADD,  16'd2, 0, 0);
    push(ALU_MUL,  16'd3, 0, 0);
    repeat (2) @(posedge clk); #1;
    check("full_in_ready",  32'(in_ready),  0);
    check("full_busy",      32'(busy),      1);
    check("full_res_valid", 32'(res_valid), 1);
    fork
      push(SEQ_EMIT, 16'd0, 1, 16'd12);
      begin
        repeat (3) @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    drain();

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_load",   32'(alu_load),   0);
      check("idle_opcode", 32'(alu_opcode), 32'hF);
      check("idle_busy",   32'(busy),       0);
    end

    // Asynchronous reset during EMIT_WAIT
    push(SEQ_LOAD, 16'd9, 0, 0);
    push(SEQ_EMIT, 16'd0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_res_valid", 32'(res_valid), 0);
    check("arst_res_data",  32'(res_data),  0);
    check("arst_busy",      32'(busy),      0);
    check_drive("arst", 1'b0, 16'd0, 4'hF);
    #1 rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 1);
    repeat (5) @(posedge clk); #1;
    check("arst_no_result", 32'(res_valid), 0);
    push(SEQ_LOAD, 16'd7, 0, 0);
    @(posedge clk); #1;
    check_drive("load", 1'b1, 16'd7, 4'hF);
    push(SEQ_EMIT, 16'd0, 1, 16'd7);
    drain();

    // Reserved opcode acts as NOP
    push(SEQ_LOAD, 16'd2, 0, 0);
    push(SEQ_RSVD, 16'd9, 0, 0);
    @(posedge clk); #1;
    check_drive("rsvd", 1'b0, 16'd0, 4'hF);
    push(SEQ_EMIT, 16'd0, 1, 16'd2);
    drain();

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
